// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Load/store bus between the CPU data path (master) and the data-memory
//   responder (slave).
//   Request : MEM_req_valid, MEM_req_ready, MEM_req_write, MEM_length,
//             MEM_read_signed, MEM_address, MEM_write_data
//   Response: MEM_resp_valid, MEM_resp_error, MEM_read_data
interface dmem_responder_if;
    logic        MEM_req_valid;
    logic        MEM_req_ready;
    logic        MEM_req_write;
    logic [1:0]  MEM_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_address;
    logic [31:0] MEM_write_data;
    logic        MEM_resp_valid;
    logic        MEM_resp_error;
    logic [31:0] MEM_read_data;

    modport master (
        output MEM_req_valid, MEM_req_write, MEM_length, MEM_read_signed,
               MEM_address, MEM_write_data,
        input  MEM_req_ready, MEM_resp_valid, MEM_resp_error, MEM_read_data
    );

    modport slave (
        input  MEM_req_valid, MEM_req_write, MEM_length, MEM_read_signed,
               MEM_address, MEM_write_data,
        output MEM_req_ready, MEM_resp_valid, MEM_resp_error, MEM_read_data
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data memory for the multi-cycle CPU. Accepts one load/store
//   at a time (valid/ready), services byte/half/word accesses little-endian,
//   sign/zero-extends load data and returns a one-cycle response strobe.
//   Optional macro DMEM_MISALIGNED_EN: when defined, accesses crossing a word
//   boundary are split over two array cycles (LO then HI); when undefined,
//   misaligned half/word accesses are rejected with an error.
// Ports
//   SYS_clk   : clock, rising edge
//   SYS_reset : synchronous active-high reset (also clears the array)
//   mem       : dmem_responder_if.slave request/response bus
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    dmem_responder_if.slave  mem
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_RESP = 2'd2
`ifdef DMEM_MISALIGNED_EN
        , S_HI = 2'd3
`endif
    } state_t;

    state_t         state_q;
    logic           ready_q;
    logic           resp_valid_q;
    logic           resp_err_q;
    logic [31:0]    rdata_q;

    logic           wr_q;
    logic [2:0]     n_q;
    logic           sgn_q;
    logic [1:0]     off_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic           err_q;
`ifdef DMEM_MISALIGNED_EN
    logic           split_q;
`endif
    logic [31:0]    acc_q;

    logic [31:0]    mem_q [DEPTH_WORDS];

    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [2:0]  n,
                                                input logic        sgn);
        logic [31:0] r;
        case (n)
            3'd1:    r = sgn ? {{24{raw[7]}},  raw[7:0]}  : {24'b0, raw[7:0]};
            3'd2:    r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'b0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Accept-time decode of the incoming request.
    logic [2:0]  req_n;
    logic [31:0] req_idx;
    logic        req_split;
    logic        req_err;

    always_comb begin
        case (mem.MEM_length)
            2'b01:   req_n = 3'd1;
            2'b10:   req_n = 3'd2;
            2'b11:   req_n = 3'd4;
            default: req_n = 3'd0;
        endcase
        req_idx   = {2'b00, mem.MEM_address[31:2]};
        req_split = ({2'b00, mem.MEM_address[1:0]} + {1'b0, req_n}) > 4'd4;
        req_err   = (mem.MEM_length == 2'b00)
                 || (req_idx >= 32'(DEPTH_WORDS))
                 || (req_split && ((req_idx + 32'd1) >= 32'(DEPTH_WORDS)));
`ifndef DMEM_MISALIGNED_EN
        if ((mem.MEM_length == 2'b10 && mem.MEM_address[0]) ||
            (mem.MEM_length == 2'b11 && mem.MEM_address[1:0] != 2'b00))
            req_err = 1'b1;
`endif
    end

    // Byte-lane steering for the word touched this cycle. pos is the operand
    // byte that lands on array lane k: lanes o.. in LO, lanes 0.. in HI carry
    // the operand bytes that did not fit in the first word.
    logic [AW-1:0] cur_idx;
    logic [31:0]   cur_word;
    logic [31:0]   acc_d;
    logic [31:0]   wword_d;

    always_comb begin
        cur_idx = idx_q;
`ifdef DMEM_MISALIGNED_EN
        if (state_q == S_HI)
            cur_idx = idx_q + AW'(1);
`endif
        cur_word = mem_q[cur_idx];
        acc_d    = acc_q;
        wword_d  = cur_word;
        for (int k = 0; k < 4; k++) begin
            int pos;
            pos = k - int'(off_q);
`ifdef DMEM_MISALIGNED_EN
            if (state_q == S_HI)
                pos = k + 4 - int'(off_q);
`endif
            if (pos >= 0 && pos < int'(n_q)) begin
                acc_d[pos*8 +: 8]  = cur_word[k*8 +: 8];
                wword_d[k*8 +: 8]  = wdata_q[pos*8 +: 8];
            end
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem_q[i] <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (mem.MEM_req_valid) begin
                        wr_q    <= mem.MEM_req_write;
                        n_q     <= req_n;
                        sgn_q   <= mem.MEM_read_signed;
                        off_q   <= mem.MEM_address[1:0];
                        idx_q   <= mem.MEM_address[AW+1:2];
                        wdata_q <= mem.MEM_write_data;
                        err_q   <= req_err;
`ifdef DMEM_MISALIGNED_EN
                        split_q <= req_split;
`endif
                        acc_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    // Erroring requests never touch the array.
                    if (!err_q) begin
                        acc_q <= acc_d;
                        if (wr_q)
                            mem_q[cur_idx] <= wword_d;
                    end
`ifdef DMEM_MISALIGNED_EN
                    if (!err_q && split_q) begin
                        state_q <= S_HI;
                    end else
`endif
                    begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        rdata_q      <= (err_q || wr_q) ? '0
                                        : extend_load(acc_d, n_q, sgn_q);
                    end
                end
`ifdef DMEM_MISALIGNED_EN
                S_HI: begin
                    acc_q <= acc_d;
                    if (wr_q)
                        mem_q[cur_idx] <= wword_d;
                    state_q      <= S_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    rdata_q      <= wr_q ? '0 : extend_load(acc_d, n_q, sgn_q);
                end
`endif
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem.MEM_req_ready  = ready_q;
    assign mem.MEM_resp_valid = resp_valid_q;
    assign mem.MEM_resp_error = resp_err_q;
    assign mem.MEM_read_data  = rdata_q;
endmodule
